irq_gateway: RTL
================

# irq_gateway

Per-source interrupt gateway sitting directly upstream of `plicdpi` in the Verilator top. It replaces the ad-hoc counter that drives `irq_sources` today. Raw interrupt lines are synchronised and qualified as level- or edge-triggered. The block presents at most one outstanding request per source on `irq_sources_o`, and blocks re-requests until the PLIC signals claim and then completion. Edge-mode sources keep a saturating count of edges that arrive while a request is outstanding, so no edges are lost up to that depth.

## Interface

**Parameters**
- `SOURCES`, default 32: number of interrupt sources; must match `plicdpi.SOURCES`.
- `SYNC_STAGES`, default 2: synchroniser depth on `irq_raw_i`; minimum 2.
- `MAX_PENDING`, default 3: saturation value of the per-source edge counter; minimum 1.
- `IdW`, default `$clog2(SOURCES)`: width of the claim and complete IDs (local parameter).

**Ports**
- `clk_i`, input, 1: the single clock for all state.
- `rst_i`, input, 1: asynchronous, active-high reset.
- `irq_raw_i`, input, SOURCES: raw interrupt lines, possibly asynchronous to `clk_i`.
- `edge_mode_i`, input, SOURCES: 1 selects rising-edge mode, 0 selects level mode; quasi-static.
- `claim_valid_i`, input, 1: one-cycle pulse, PLIC has claimed `claim_id_i`.
- `claim_id_i`, input, IdW: bit index of the claimed source.
- `complete_valid_i`, input, 1: one-cycle pulse, handler has completed `complete_id_i`.
- `complete_id_i`, input, IdW: bit index of the completed source.
- `irq_sources_o`, output, SOURCES: registered request levels, connected to `plicdpi.irq_sources_i`.
- `inflight_o`, output, SOURCES: source has been claimed and is awaiting completion.

## Operation

**Front end**
- Each `irq_raw_i` bit passes through `SYNC_STAGES` flops, giving `s`.
- A further flop holds `s_q`.
- `edge_det = s & ~s_q`.

**Per-source FSM**
- States: `IDLE`, `REQ`, `INFLIGHT`.
- `IDLE` → `REQ` when the trigger is true:
  - Level mode: trigger is `s`.
  - Edge mode: trigger is `edge_det` or `cnt != 0`.
  - If the move is due to `cnt != 0` and no new edge arrives, `cnt` decrements by one.
- `REQ` → `INFLIGHT` on `claim_valid_i && claim_id_i == i`.
- `INFLIGHT` → `REQ` or `IDLE` on `complete_valid_i && complete_id_i == i`:
  - Level mode: go to `REQ` if `s` is high, else `IDLE`.
  - Edge mode: go to `REQ` if `cnt != 0`, else `IDLE`.
- Encoding: `irq_sources_o[i] = (state == REQ)`; `inflight_o[i] = (state == INFLIGHT)`.

**Edge counter** (`cnt`, width `$clog2(MAX_PENDING+1)`)
- In `REQ` or `INFLIGHT`, `edge_det` increments `cnt`, saturating at `MAX_PENDING`.
- In `IDLE`, an edge triggers `REQ` directly and is not counted.
- On a completion that re-requests, `cnt` decrements.
- If an edge and a re-requesting completion happen in the same cycle, `cnt` is unchanged.
- `cnt` is held at 0 whenever `edge_mode_i[i] = 0`.

**Boundary conditions**
- A claim or complete whose ID is ≥ `SOURCES` is ignored.
- A claim for a source not in `REQ` is ignored.
- A complete for a source not in `INFLIGHT` is ignored.
- Claim and complete in the same cycle for the same source in `REQ`: the claim applies (→ `INFLIGHT`), the complete is ignored.
- Level-mode source dropping while in `REQ`: the request is held. Gateways never retract a request; the PLIC is responsible for handling it.
- Changing `edge_mode_i` mid-transaction does not alter the current state; the new mode applies at the next trigger evaluation.

**Reset** (`rst_i` high, any time, mid-transaction included)
- Every state goes to `IDLE`; `cnt`, synchroniser flops and `s_q` clear to 0.
- `irq_sources_o` and `inflight_o` go to 0 asynchronously.
- After release, an edge-mode line that is already high produces one edge, because `s_q` = 0.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Raw-to-request latency: `irq_raw_i` high before edge 1 gives `irq_sources_o` high after edge `SYNC_STAGES+1` (3 cycles at default).
- Claim pulse sampled at edge k: `irq_sources_o` low and `inflight_o` high after edge k.
- Complete sampled at edge k with a re-request condition: `irq_sources_o` high after edge k, with no idle cycle in between.
- Throughput: one claim and one complete can be accepted per cycle (different or the same ID, subject to the state rules above).
- Edge-mode pulses must be held at least `SYNC_STAGES+1` cycles high and 2 cycles low to be detected.

## Test plan
1. **Edge, single:** source 0 in edge mode, 1-cycle-wide-plus-hold pulse on `irq_raw_i[0]`. Expect `irq_sources_o[0]` = 1 exactly 3 cycles later. Claim id 0 → `irq_sources_o` = 0, `inflight_o[0]` = 1. Complete id 0 → all outputs 0.
2. **Edge, saturation:** source 3 in edge mode; after the claim, deliver 5 edges before completing; `MAX_PENDING` = 3. Expect exactly 3 further `REQ`/`INFLIGHT` rounds, then `IDLE`.
3. **Level, re-request:** source 5 in level mode, held high. Claim, then complete. Expect `irq_sources_o[5]` high the cycle after the complete. Drop the line, claim, complete → `IDLE`.
4. **Invalid handshakes:** complete id 7 while it is in `REQ` → no change. Claim id 31 while it is `IDLE` → no change. With `SOURCES` = 20, claim id 25 → ignored.
5. **Simultaneous events:** edge on source 2 in the same cycle as its re-requesting complete, with `cnt` = 1. Expect `REQ` with `cnt` still 1.
6. **Reset mid-flight:** sources 0 and 1 `INFLIGHT`, `cnt` = 2; assert `rst_i` asynchronously mid-cycle. Expect outputs 0 immediately. After release with `irq_raw_i[0]` still high in edge mode, expect exactly one new request.

Source files
------------

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway: synchronises raw lines, qualifies them as level or
// rising-edge, and holds one outstanding request per source until claim and completion.
module irq_gateway #(
  parameter int SOURCES     = 32,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_PENDING = 3,
  localparam int IdW        = (SOURCES > 1) ? $clog2(SOURCES) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [SOURCES-1:0] irq_raw_i,
  input  logic [SOURCES-1:0] edge_mode_i,
  input  logic               claim_valid_i,
  input  logic [IdW-1:0]     claim_id_i,
  input  logic               complete_valid_i,
  input  logic [IdW-1:0]     complete_id_i,
  output logic [SOURCES-1:0] irq_sources_o,
  output logic [SOURCES-1:0] inflight_o
);

  localparam int CntW = $clog2(MAX_PENDING + 1);

  typedef logic [CntW-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, REQ, INFLIGHT} state_e;

  localparam cnt_t CntMax = cnt_t'(MAX_PENDING);
  localparam cnt_t CntOne = cnt_t'(1);

  logic [SYNC_STAGES-1:0][SOURCES-1:0] sync_q, sync_d;
  logic [SOURCES-1:0] s, s_q, s_d, edge_det;
  logic [SOURCES-1:0] claim_hit, complete_hit, cnt_inc;
  state_e state_q [SOURCES];
  state_e state_d [SOURCES];
  cnt_t   cnt_q   [SOURCES];
  cnt_t   cnt_d   [SOURCES];

  assign s        = sync_q[SYNC_STAGES-1];
  assign edge_det = s & ~s_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], irq_raw_i};
    s_d    = s;
  end

  // IDs at or above SOURCES never match any loop index, so they fall out naturally.
  always_comb begin
    for (int i = 0; i < SOURCES; i++) begin
      claim_hit[i]    = claim_valid_i    && (claim_id_i    == IdW'(i));
      complete_hit[i] = complete_valid_i && (complete_id_i == IdW'(i));
      cnt_inc[i]      = edge_det[i] && (cnt_q[i] != CntMax);
    end
  end

  always_comb begin
    for (int i = 0; i < SOURCES; i++) begin
      // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (edge_mode_i[i]) begin
            if (edge_det[i]) begin
              state_d[i] = REQ;
            end else if (cnt_q[i] != '0) begin
              state_d[i] = REQ;
              cnt_d[i]   = cnt_q[i] - CntOne;
            end
          end else if (s[i]) begin
            state_d[i] = REQ;
          end
        end
        REQ: begin
          // A simultaneous complete is ignored here: it only matters in INFLIGHT.
          if (claim_hit[i]) state_d[i] = INFLIGHT;
          if (cnt_inc[i])   cnt_d[i]   = cnt_q[i] + CntOne;
        end
        INFLIGHT: begin
          if (complete_hit[i] && (edge_mode_i[i] ? (cnt_q[i] != '0) : s[i])) begin
            state_d[i] = REQ;
            if (!edge_det[i]) cnt_d[i] = cnt_q[i] - CntOne;
          end else begin
            if (complete_hit[i]) state_d[i] = IDLE;
            if (cnt_inc[i])      cnt_d[i]   = cnt_q[i] + CntOne;
          end
        end
        default: state_d[i] = IDLE;
      endcase
      if (!edge_mode_i[i]) cnt_d[i] = '0;
    end
  end

  // NOTE: every flop here, including the per-source arrays, is cleared by the async reset so outputs drop immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      s_q    <= '0;
      for (int i = 0; i < SOURCES; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      sync_q <= sync_d;
      s_q    <= s_d;
      for (int i = 0; i < SOURCES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < SOURCES; i++) begin
      irq_sources_o[i] = (state_q[i] == REQ);
      inflight_o[i]    = (state_q[i] == INFLIGHT);
    end
  end

endmodule
